// File: rtl/chaotic_keystream_gen.sv
// Multi-channel logistic-map keystream generator: NUM_CH map states iterated
// round-robin through a shared two-stage fixed-point datapath x' = r*x*(1-x).
module chaotic_keystream_gen #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FRAC_BITS   = 30,
  parameter int                    R_FRAC_BITS = 28,
  parameter int                    NUM_CH      = 4,
  parameter logic [DATA_WIDTH-1:0] SEED_BASE   = 32'h0F9ADD3F,
  parameter logic [DATA_WIDTH-1:0] R_RESET     = 32'h40000000,
  localparam int                   CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  r_we,
  input  logic [DATA_WIDTH-1:0] r_in,
  input  logic                  load_en,
  input  logic [CW-1:0]         load_ch,
  input  logic [DATA_WIDTH-1:0] load_state,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic [DATA_WIDTH-1:0] key_data,
  output logic [CW-1:0]         key_ch,
  output logic                  degen_pulse,
  output logic                  busy
);

  localparam int                    PW  = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC_BITS;

  typedef enum logic [1:0] {S_IDLE, S_CALC1, S_CALC2, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic [DATA_WIDTH-1:0] omx_q, omx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] key_data_q, key_data_d;
  logic                  degen_q, degen_d;
  logic [DATA_WIDTH-1:0] x_q [NUM_CH];
  logic [DATA_WIDTH-1:0] x_d [NUM_CH];
  logic [DATA_WIDTH-1:0] seed_v [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_seed
    assign seed_v[gi] = SEED_BASE + DATA_WIDTH'(gi) * DATA_WIDTH'(32'h0100_0000);
  end

  logic [DATA_WIDTH-1:0] x_sel;
  logic [PW-1:0]         rx_full;
  logic [PW-1:0]         y_full;
  logic [DATA_WIDTH-1:0] y_sat;
  logic [DATA_WIDTH-1:0] wb_val;
  logic                  degenerate;
  logic                  load_hit;
  logic                  abort;

  always_comb begin
    x_sel      = x_q[c_q];
    rx_full    = (PW'(r_q) * PW'(x_sel)) >> R_FRAC_BITS;
    y_full     = (PW'(rx_q) * PW'(omx_q)) >> FRAC_BITS;
    y_sat      = (y_full > PW'(ONE)) ? ONE : y_full[DATA_WIDTH-1:0];
    // A zero orbit or a fixed point would repeat the same key forever.
    degenerate = (y_sat == '0) || (y_sat == x_sel);
    wb_val     = degenerate ? (seed_v[c_q] + DATA_WIDTH'(1)) : y_sat;
    load_hit   = load_en && ({{(32-CW){1'b0}}, load_ch} < 32'(NUM_CH));
    abort      = load_hit && (load_ch == c_q) && (state_q != S_IDLE);
  end

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    rr_d       = rr_q;
    r_d        = r_we ? r_in : r_q;
    omx_d      = omx_q;
    rx_d       = rx_q;
    key_data_d = key_data_q;
    degen_d    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      x_d[i] = x_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          c_d     = rr_q;
          state_d = S_CALC1;
        end
      end
      S_CALC1: begin
        omx_d   = (x_sel > ONE) ? '0 : ONE - x_sel;
        rx_d    = (rx_full[PW-1:DATA_WIDTH] != '0) ? '1 : rx_full[DATA_WIDTH-1:0];
        state_d = S_CALC2;
      end
      S_CALC2: begin
        x_d[c_q]   = wb_val;
        key_data_d = wb_val;
        degen_d    = degenerate;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (key_ready) begin
          rr_d    = (c_q == CW'(NUM_CH - 1)) ? '0 : c_q + CW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A resync of the channel in flight invalidates its result; it is redone.
    if (abort) begin
      state_d = S_IDLE;
      degen_d = 1'b0;
      rr_d    = rr_q;
    end
    if (load_hit) begin
      x_d[load_ch] = load_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      rr_q       <= '0;
      r_q        <= R_RESET;
      omx_q      <= '0;
      rx_q       <= '0;
      key_data_q <= '0;
      degen_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        x_q[i] <= seed_v[i];
      end
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      rr_q       <= rr_d;
      r_q        <= r_d;
      omx_q      <= omx_d;
      rx_q       <= rx_d;
      key_data_q <= key_data_d;
      degen_q    <= degen_d;
      for (int i = 0; i < NUM_CH; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

  assign key_valid   = (state_q == S_OUT);
  assign key_data    = key_data_q;
  assign key_ch      = c_q;
  assign degen_pulse = degen_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_chaotic_keystream_gen.sv
// Scoreboard bench for chaotic_keystream_gen: stimulus pushes expected keys,
// a negedge monitor pops and compares each accepted key.
module tb_chaotic_keystream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        r_we;
  logic [31:0] r_in;
  logic        load_en;
  logic [1:0]  load_ch;
  logic [31:0] load_state;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_data;
  logic [1:0]  key_ch;
  logic        degen_pulse;
  logic        busy;

  chaotic_keystream_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .r_we(r_we), .r_in(r_in),
    .load_en(load_en), .load_ch(load_ch), .load_state(load_state),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .key_ch(key_ch), .degen_pulse(degen_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ch;
    logic        degen;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] xm [4];
  logic [31:0] rm;
  int          rrm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] seed(input int c);
    return 32'h0F9ADD3F + 32'(c) * 32'h0100_0000;
  endfunction

  // Reference iteration straight from the arithmetic rules of the map.
  function automatic logic [31:0] step(input logic [31:0] x, input logic [31:0] r,
                                       input logic [31:0] reseed, output logic dg);
    logic [63:0] rx64, y64;
    logic [31:0] rx, omx, y;
    rx64 = ({32'b0, r} * {32'b0, x}) >> 28;
    rx   = (rx64 > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : rx64[31:0];
    omx  = (x > 32'h4000_0000) ? 32'h0 : 32'h4000_0000 - x;
    y64  = ({32'b0, rx} * {32'b0, omx}) >> 30;
    y    = (y64 > 64'h4000_0000) ? 32'h4000_0000 : y64[31:0];
    dg   = (y == 32'h0) || (y == x);
    return dg ? reseed : y;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) xm[c] = seed(c);
    rm  = 32'h4000_0000;
    rrm = 0;
  endtask

  task automatic push_model();
    exp_t e;
    logic dg;
    logic [31:0] nx;
    nx = step(xm[rrm], rm, seed(rrm) + 32'd1, dg);
    xm[rrm] = nx;
    e.data = nx; e.ch = 2'(rrm); e.degen = dg;
    sb.push_back(e);
    rrm = (rrm + 1) % 4;
  endtask

  task automatic push_hand(input logic [31:0] data, input logic dg);
    exp_t e;
    xm[rrm] = data;
    e.data = data; e.ch = 2'(rrm); e.degen = dg;
    sb.push_back(e);
    rrm = (rrm + 1) % 4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !key_valid; i++) tick();
    if (!key_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got key_valid=0 expected key_valid=1");
    end
  endtask

  task automatic run_iter(input bit chk_lat);
    wait_idle();
    key_ready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    if (chk_lat) check("lat_calc2_valid", 32'(key_valid), 32'd0);
    tick();
    if (chk_lat) check("lat_out_valid", 32'(key_valid), 32'd1);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load(input logic [1:0] ch, input logic [31:0] v);
    load_en = 1'b1; load_ch = ch; load_state = v;
    tick();
    load_en = 1'b0;
    xm[ch] = v;
  endtask

  // Monitor: compares every accepted key and checks that a stalled key holds still.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_ch;
  logic        rise_degen;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        if (!prev_valid) begin
          rise_degen = degen_pulse;
        end else begin
          check("stall_data_stable", key_data, prev_data);
          check("stall_ch_stable", 32'(key_ch), 32'(prev_ch));
        end
        if (key_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_key: got ch=%0d data=%h expected no key", key_ch, key_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            pops++;
            check("key_data", key_data, e.data);
            check("key_ch", 32'(key_ch), 32'(e.ch));
            check("degen_pulse", 32'(rise_degen), 32'(e.degen));
          end
        end
      end
      prev_valid = key_valid && !key_ready;
      prev_data  = key_data;
      prev_ch    = key_ch;
    end
  end

  initial begin
    int pops0;
    rst = 1'b1; enable = 1'b0; r_we = 1'b0; r_in = 32'h0;
    load_en = 1'b0; load_ch = 2'd0; load_state = 32'h0; key_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    model_reset();

    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_data", key_data, 32'h0);
    check("rst_key_ch", 32'(key_ch), 32'd0);
    check("rst_degen", 32'(degen_pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Round-robin 0,1,2,3,0 from the reset seeds with r = 4.0.
    for (int i = 0; i < 5; i++) begin
      push_model();
      run_iter(i == 0);
    end

    // x0 = 0.5 -> 1.0, then 1.0 collapses to 0 and reseeds.
    do_reset();
    load(2'd0, 32'h2000_0000);
    push_hand(32'h4000_0000, 1'b0); run_iter(1'b0);
    for (int i = 0; i < 3; i++) begin push_model(); run_iter(1'b0); end
    push_hand(32'h0F9A_DD40, 1'b1); run_iter(1'b0);

    // x0 = 0.25 -> 0.75, which is a fixed point of r = 4.0.
    do_reset();
    load(2'd0, 32'h1000_0000);
    push_hand(32'h3000_0000, 1'b0); run_iter(1'b0);
    for (int i = 0; i < 3; i++) begin push_model(); run_iter(1'b0); end
    push_hand(32'h0F9A_DD40, 1'b1); run_iter(1'b0);

    // Backpressure: hold ready low for 10 cycles, then a single-cycle ready.
    wait_idle();
    key_ready = 1'b0;
    push_model();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_valid();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid_held", 32'(key_valid), 32'd1);
    end
    enable = 1'b0;
    pops0 = pops;
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("one_transfer", 32'(pops - pops0), 32'd1);
    check("after_xfer_valid", 32'(key_valid), 32'd0);
    tick(); tick();
    check("no_new_iter_busy", 32'(busy), 32'd0);
    key_ready = 1'b1;

    // r = 3.0 with x0 = 0.5, then abort the ch1 iteration in CALC2.
    do_reset();
    r_we = 1'b1; r_in = 32'h3000_0000;
    rm = 32'h3000_0000;
    load(2'd0, 32'h2000_0000);
    r_we = 1'b0;
    push_hand(32'h3000_0000, 1'b0); run_iter(1'b0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    load_en = 1'b1; load_ch = 2'd1; load_state = 32'h2000_0000;
    tick();
    load_en = 1'b0;
    xm[1] = 32'h2000_0000;
    check("abort_valid", 32'(key_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick(); tick();
    check("abort_no_key", 32'(key_valid), 32'd0);
    push_hand(32'h3000_0000, 1'b0); run_iter(1'b0);

    // Reset while a key is pending: it must vanish and state restart from seeds.
    wait_idle();
    key_ready = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_valid();
    rst = 1'b1;
    tick();
    check("rst_out_valid", 32'(key_valid), 32'd0);
    check("rst_out_data", key_data, 32'h0);
    check("rst_out_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_reset();
    key_ready = 1'b1;
    push_model(); run_iter(1'b1);
    push_model(); run_iter(1'b0);

    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chaotic_keystream_gen.md
Name: chaotic_keystream_gen

Overview:
- Multi-channel successor to the single logistic-map key generator.
- Holds NUM_CH independent logistic-map states x[c] and iterates them round-robin through one shared two-stage fixed-point datapath: x' = r*x*(1-x).
- Emits one key word per iteration on a valid/ready stream, with runtime-programmable r, per-channel resync load, and degenerate-orbit detection with automatic reseed.
- Sits between the frame sync/keying logic and the audio XOR cipher.

Parameters:
- DATA_WIDTH, 32, width of x, r and key words.
- FRAC_BITS, 30, fractional bits of x (Q2.30 by default); ONE = 1 << FRAC_BITS.
- R_FRAC_BITS, 28, fractional bits of r (Q4.28 by default).
- NUM_CH, 4, number of independent map channels (>= 1).
- SEED_BASE, 32'h0F9ADD3F, reset seed; channel c resets to SEED_BASE + c*32'h01000000.
- R_RESET, 32'h40000000, reset value of r (4.0 in Q4.28).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  allows new iterations to start
- r_we  in  1  write strobe for r
- r_in  in  DATA_WIDTH  new r value
- load_en  in  1  force a channel state (resync)
- load_ch  in  $clog2(NUM_CH) (min 1)  channel to load
- load_state  in  DATA_WIDTH  state value to load
- key_valid  out  1  key word available
- key_ready  in  1  consumer accepts key
- key_data  out  DATA_WIDTH  new state x'[c]
- key_ch  out  $clog2(NUM_CH) (min 1)  channel that produced key_data
- degen_pulse  out  1  one-cycle flag: the iteration was degenerate and was reseeded
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: x[c] = SEED_BASE + c*0x01000000; r = R_RESET; rr pointer = 0; FSM = IDLE; key_valid = 0; key_data = 0; key_ch = 0; degen_pulse = 0; busy = 0.
- FSM states IDLE -> CALC1 -> CALC2 -> OUT -> IDLE.
- IDLE: if enable, latch c = rr and go to CALC1.
- CALC1: register omx = (x[c] > ONE) ? 0 : ONE - x[c]. Register rx = (r*x[c]) >> R_FRAC_BITS using a 2*DATA_WIDTH product; saturate to all-ones if the result exceeds DATA_WIDTH bits.
- CALC2: y = (rx*omx) >> FRAC_BITS; saturate to ONE if y > ONE. Write back in the same cycle, then go to OUT.
- Degenerate check in CALC2: y == 0 or y == x[c] (stuck or fixed point). If degenerate, x[c] = SEED_BASE + c*0x01000000 + 1 and degen_pulse = 1 for one cycle. Otherwise x[c] = y.
- OUT: key_valid = 1, key_data = value written to x[c], key_ch = c. Data is held stable until key_valid && key_ready. On acceptance, rr = (c+1) mod NUM_CH, go to IDLE.
- Latency: first key_valid is 3 cycles after the IDLE cycle with enable=1. Maximum throughput is 1 key per 4 cycles.
- enable deasserted mid-iteration: the iteration completes and its key is still delivered.
- r_we: r updates at the clock edge. An iteration in CALC1 uses the r present at that edge's sampling (old r if r_we is in the same cycle).
- load_en: x[load_ch] = load_state at the edge, highest priority over writeback.
  - If load_ch == c and the FSM is in CALC1, CALC2 or OUT: the in-flight iteration is aborted, key_valid drops next cycle (no key emitted), the FSM returns to IDLE, and rr is unchanged.
  - Loads to other channels do not disturb the in-flight iteration.
- load_ch >= NUM_CH: ignored.
- rst mid-operation: all state returns to reset values at the next edge. No pending key survives.
- Wrap: rr wraps NUM_CH-1 -> 0. With NUM_CH = 1, rr stays 0.

Test Plan:
- Reset, enable=1, key_ready=1, defaults: first key_valid 3 cycles after enable. key_ch sequence 0,1,2,3,0. Each key_data matches the bit-exact reference model of the rules above.
- load_en ch0 = 0x20000000 (0.5), r = 4.0: ch0 key = 0x40000000 (1.0). Next ch0 iteration gives y = 0, so degen_pulse = 1 and ch0 key = 0x0F9ADD40.
- load ch0 = 0x10000000 (0.25): key = 0x30000000 (0.75). Next ch0 iteration equals x, so it is degenerate and reseeds to 0x0F9ADD40 with degen_pulse.
- key_ready held low for 10 cycles in OUT: key_valid, key_data and key_ch stay stable and no further iteration starts. One-cycle ready -> exactly one transfer.
- r_we = 0x30000000 (3.0), load ch0 = 0x20000000: key = 0x30000000 (0.75). load_en targeting the in-flight channel during CALC2 -> no key emitted, x = load_state, same channel re-iterated next.
- rst asserted during OUT: key_valid = 0 next cycle. All states return to seeds, r = 4.0, rr = 0.
